// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3-style) field definitions and pack/unpack helpers.
package fp8_pkg;

  localparam int FP8_W   = 8;
  localparam int EXP_W   = 4;
  localparam int MAN_W   = 3;
  localparam int BIAS    = 7;
  // Adding (2^EXP_W - BIAS) is the same as subtracting the bias modulo 2^EXP_W.
  localparam int EXP_ADJ = (1 << EXP_W) - BIAS;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp8_t;

  function automatic fp8_t fp8_unpack(input logic [FP8_W-1:0] x);
    return fp8_t'(x);
  endfunction

  function automatic logic [FP8_W-1:0] fp8_pack(input logic s,
                                                input logic [EXP_W-1:0] e,
                                                input logic [MAN_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp8_mul_arbiter_if.sv
// Request/response bundle between the MAC lanes and the shared FP8 multiplier.
interface fp8_mul_arbiter_if
  import fp8_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*FP8_W-1:0] req_a;
  logic [N*FP8_W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [FP8_W-1:0]   rsp_product;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id
  );

endinterface

// File: rtl/FP8_multiplier.sv
// Truncating FP8 multiplier core; no saturation, NaN or subnormal handling.
module FP8_multiplier
  import fp8_pkg::*;
(
  input  logic [FP8_W-1:0] a_i,
  input  logic [FP8_W-1:0] b_i,
  output logic [FP8_W-1:0] y_o
);

  fp8_t                   a_f, b_f;
  logic [2*MAN_W+1:0]     sig_p;
  logic                   carry;
  logic [EXP_W-1:0]       exp_y;
  logic [MAN_W-1:0]       man_y;

  assign a_f   = fp8_unpack(a_i);
  assign b_f   = fp8_unpack(b_i);
  assign sig_p = (2*MAN_W+2)'({1'b1, a_f.man}) * (2*MAN_W+2)'({1'b1, b_f.man});
  assign carry = sig_p[2*MAN_W+1];
  // Product of two 1.xxx significands is in [1,4); a set top bit means renormalise by one.
  assign man_y = carry ? MAN_W'(sig_p >> (MAN_W + 1)) : MAN_W'(sig_p >> MAN_W);
  assign exp_y = a_f.exp + b_f.exp + EXP_W'(EXP_ADJ) + EXP_W'(carry);
  assign y_o   = fp8_pack(a_f.sign ^ b_f.sign, exp_y, man_y);

endmodule

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: first requester after ptr wins, searching upward modulo N.
module rr_arbiter_n #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// Time-shares one FP8 multiplier among N requesters with round-robin grant
// and a single registered, back-pressurable response stage.
module fp8_mul_arbiter
  import fp8_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDW  = $clog2(N),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  fp8_mul_arbiter_if.slave bus,
  output logic [CNTW-1:0] ops_count
);

  logic [N-1:0]     grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   ptr_q;
  logic             adv;
  logic             rsp_valid_q;
  logic [FP8_W-1:0] rsp_product_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [CNTW-1:0]  ops_q, ops_d;
  logic [FP8_W-1:0] mul_y;
  logic [FP8_W-1:0] a_arr [N];
  logic [FP8_W-1:0] b_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[FP8_W*gi +: FP8_W];
      assign b_arr[gi] = bus.req_b[FP8_W*gi +: FP8_W];
    end
  endgenerate

  // The output slot frees up either because it is empty or because it drains this cycle.
  assign adv = !rsp_valid_q || bus.rsp_ready;

  rr_arbiter_n #(.N(N), .IDW(IDW)) u_arb (
    .req      (bus.req_valid),
    .en       (adv),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  FP8_multiplier u_mul (
    .a_i (a_arr[grant_id]),
    .b_i (b_arr[grant_id]),
    .y_o (mul_y)
  );

  assign ops_d = ops_q + CNTW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
      ops_q         <= '0;
      ptr_q         <= IDW'(N - 1);
    end else begin
      if (rsp_valid_q && bus.rsp_ready) ops_q <= ops_d;
      if (adv) begin
        if (|grant) begin
          rsp_valid_q   <= 1'b1;
          rsp_product_q <= mul_y;
          rsp_id_q      <= grant_id;
          ptr_q         <= grant_id;
        end else begin
          rsp_valid_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_id      = rsp_id_q;
  assign ops_count       = ops_q;

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Directed bench for fp8_mul_arbiter: arithmetic, round robin, backpressure, reset and counter wrap.
module tb_fp8_mul_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic            clk;
  logic            rst;
  logic [CNTW-1:0] ops_count;

  int chk_cnt;
  int err_cnt;

  logic [7:0] bvals [4] = '{8'h40, 8'h48, 8'h50, 8'h58};

  fp8_mul_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  fp8_mul_arbiter #(.N(N), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ops_count (ops_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("chk  %s: got %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*idx +: 8] = a;
    bus.req_b[8*idx +: 8] = b;
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_product", 32'(bus.rsp_product), 0);
    check("rst_id", 32'(bus.rsp_id), 0);
    check("rst_ops", 32'(ops_count), 0);
    rst = 1'b0;

    // Single op: 1.0 * 2.0
    set_op(0, 8'h38, 8'h40);
    bus.req_valid = 4'b0001;
    #1 check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("single_valid", 32'(bus.rsp_valid), 1);
    check("single_prod", 32'(bus.rsp_product), 32'h40);
    check("single_id", 32'(bus.rsp_id), 0);
    bus.req_valid = '0;
    tick();
    check("single_drain", 32'(bus.rsp_valid), 0);
    check("single_ops", 32'(ops_count), 1);

    // Mantissa carry, then sign with simultaneous hand-off and accept
    set_op(2, 8'h3C, 8'h3C);
    bus.req_valid = 4'b0100;
    #1 check("carry_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check("carry_prod", 32'(bus.rsp_product), 32'h41);
    check("carry_id", 32'(bus.rsp_id), 2);
    set_op(1, 8'hB8, 8'h40);
    bus.req_valid = 4'b0010;
    #1 check("sign_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check("sign_prod", 32'(bus.rsp_product), 32'hC0);
    check("sign_id", 32'(bus.rsp_id), 1);
    check("sign_ops", 32'(ops_count), 2);
    bus.req_valid = '0;
    tick();
    check("sign_ops2", 32'(ops_count), 3);

    // Round robin from a fresh pointer; a=1.0 so each product equals its b
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_rst_ops", 32'(ops_count), 0);
    for (int i = 0; i < N; i++) set_op(i, 8'h38, bvals[i]);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check($sformatf("rr_ready%0d", c), 32'(bus.req_ready), 32'(1 << (c % 4)));
      tick();
      check($sformatf("rr_valid%0d", c), 32'(bus.rsp_valid), 1);
      check($sformatf("rr_id%0d", c), 32'(bus.rsp_id), 32'(c % 4));
      check($sformatf("rr_prod%0d", c), 32'(bus.rsp_product), 32'(bvals[c % 4]));
    end
    bus.req_valid = '0;
    tick();
    check("rr_ops", 32'(ops_count), 8);

    // Backpressure: hold requester 0's result while 1 and 2 wait
    bus.req_valid = 4'b0001;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("bp_ready%0d", c), 32'(bus.req_ready), 0);
      tick();
      check($sformatf("bp_valid%0d", c), 32'(bus.rsp_valid), 1);
      check($sformatf("bp_prod%0d", c), 32'(bus.rsp_product), 32'h40);
      check($sformatf("bp_id%0d", c), 32'(bus.rsp_id), 0);
    end
    check("bp_ops_hold", 32'(ops_count), 8);
    bus.rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check("bp_next_id", 32'(bus.rsp_id), 1);
    check("bp_next_prod", 32'(bus.rsp_product), 32'h48);
    check("bp_ops", 32'(ops_count), 9);
    bus.req_valid = 4'b0100;
    #1 check("bp_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    check("bp_id2", 32'(bus.rsp_id), 2);
    check("bp_ops2", 32'(ops_count), 10);

    // Reset while a result is stalled; pointer must restart at requester 0
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    rst = 1'b1;
    tick();
    check("mrst_valid", 32'(bus.rsp_valid), 0);
    check("mrst_ops", 32'(ops_count), 0);
    check("mrst_id", 32'(bus.rsp_id), 0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 check("mrst_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check("mrst_prod", 32'(bus.rsp_product), 32'h48);
    check("mrst_rid", 32'(bus.rsp_id), 1);

    // Counter wrap at 4 bits
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 14) check("wrap_ops15", 32'(ops_count), 15);
    end
    check("wrap_ops16", 32'(ops_count), 0);
    bus.req_valid = '0;
    tick();
    check("wrap_ops17", 32'(ops_count), 1);
    check("wrap_valid", 32'(bus.rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
